// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: add/sub/and/or/xor/slt in 1 edge, sll/srl iterative at 1 bit/edge (k+1 edges) unless ALU_BARREL_SHIFT_EN.
// Latency: 1 edge for non-shift ops or shamt 0, k+1 edges for a shift by k; ALU_BARREL_SHIFT_EN makes every op 1 edge.
// Backpressure: result held in DONE until out_ready; in_ready low while shifting or stalled, back-to-back accept when drained.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             xfer;

`ifndef ALU_BARREL_SHIFT_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] shifted;

    assign shifted = left_q ? (res_q << 1) : (res_q >> 1);
`endif

    assign shamt    = SrcB[SHW-1:0];
    assign is_shift = (ALUControl[2:1] == 2'b11);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign xfer     = in_valid && in_ready;

    // Shift cases also cover shamt 0 in the iterative build (result is SrcA).
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            3'b000:  alu_res = SrcA + SrcB;
            3'b001:  alu_res = SrcA - SrcB;
            3'b010:  alu_res = SrcA & SrcB;
            3'b011:  alu_res = SrcA | SrcB;
            3'b100:  alu_res = SrcA ^ SrcB;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            3'b110:  alu_res = SrcA << shamt;
            default: alu_res = SrcA >> shamt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifndef ALU_BARREL_SHIFT_EN
        cnt_d   = cnt_q;
        left_d  = left_q;
`endif
        if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
        end
`ifndef ALU_BARREL_SHIFT_EN
        if (state_q == SHIFT) begin
            res_d = shifted;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                state_d = DONE;
                zero_d  = (shifted == '0);
            end
        end
`endif
        if (xfer) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (is_shift && (shamt != '0)) begin
                state_d = SHIFT;
                res_d   = SrcA;
                cnt_d   = shamt;
                left_d  = ~ALUControl[0];
            end else
`endif
            begin
                state_d = DONE;
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q   <= '0;
            left_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q   <= cnt_d;
            left_q  <= left_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign ALUResult = res_q;
    assign Zero      = zero_q;

`ifdef ALU_BARREL_SHIFT_EN
    logic unused_shamt_bits;
    assign unused_shamt_bits = is_shift;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: cycle-level reference model plus directed scenarios and randomized traffic.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ALUControl = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;
    logic        Zero;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    bit rand_or  = 1'b0;
    bit or_fixed = 1'b1;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_or ? ($urandom_range(0, 9) < 7) : or_fixed;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    // Extra edges beyond the accepting edge before the result is visible.
    function automatic int extra_edges(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return (op == 3'd6 && b == 32'hFFFF_FFFF) ? 1 : 0;
`else
        return (op >= 3'd6) ? int'(b[4:0]) : 0;
`endif
    endfunction

    // Reference model: one outstanding op, visible from cycle m_done until consumed.
    bit          m_pend = 1'b0;
    int          m_done = 0;
    logic [31:0] m_res  = '0;
    always @(negedge clk) begin
        bit ev, er;
        if (!rst_n) begin
            m_pend = 1'b0;
        end else begin
            ev = m_pend && (cyc >= m_done);
            er = !m_pend || (ev && out_ready);
            check("out_valid", {31'd0, out_valid}, {31'd0, ev});
            check("in_ready", {31'd0, in_ready}, {31'd0, er});
            if (ev) begin
                check("ALUResult", ALUResult, m_res);
                check("Zero", {31'd0, Zero}, {31'd0, (m_res == 32'd0)});
            end
            if (ev && out_ready) m_pend = 1'b0;
            if (in_valid && er) begin
                m_pend = 1'b1;
                m_res  = model(ALUControl, SrcA, SrcB);
                m_done = cyc + 1 + extra_edges(ALUControl, 32'd0) + extra_edges(ALUControl, SrcB);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int acc;
        bit found;
        found = 1'b0;
        drive(op, a, b, acc);
        if (out_valid) found = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        check({nm, "_valid"}, {31'd0, found}, 32'd1);
        check({nm, "_latency"}, cyc - acc + 1, exp_lat);
        check({nm, "_result"}, ALUResult, exp);
        check({nm, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", nchk);
        $fatal(1);
    end

    initial begin
        int acc, t0, rel, sl;
        logic [2:0]  op;
        logic [31:0] a, b;
`ifdef ALU_BARREL_SHIFT_EN
        sl = 0;
`else
        sl = 1;
`endif
        check("model_add", model(3'd0, 32'd5, 32'd7), 32'd12);
        check("model_slt", model(3'd5, 32'hFFFF_FFFF, 32'd1), 32'd1);
        check("model_sll", model(3'd6, 32'd1, 32'h25), 32'h20);

        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", {31'd0, Zero}, 32'd0);
        #19 rst_n = 1'b1;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        run_op("add", 3'd0, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub_zero", 3'd1, 32'd9, 32'd9, 32'd0, 1);
        run_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("slt_pos", 3'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("sll5", 3'd6, 32'd1, 32'h25, 32'h20, sl ? 6 : 1);
        run_op("srl31", 3'd7, 32'h8000_0000, 32'd31, 32'd1, sl ? 32 : 1);
        run_op("sll0", 3'd6, 32'h1234, 32'h40, 32'h1234, 1);
        run_op("srl_to_zero", 3'd7, 32'h0000_0008, 32'd4, 32'd0, sl ? 5 : 1);

        // Backpressure then release with a simultaneous new operation.
        drive(3'd4, 32'hF0, 32'hFF, acc);
        or_fixed = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_hold_result", ALUResult, 32'h0F);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        rel = cyc;
        or_fixed = 1'b1;
        drive(3'd3, 32'd3, 32'd4, acc);
        check("bp_no_bubble", acc - rel, 32'd1);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", ALUResult, 32'd7);

        // Eight consecutive ops with the consumer always ready.
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i % 4 == 3 ? 0 : i % 4);
            drive(op, $urandom, $urandom, acc);
        end
        check("b2b_cycles", cyc - t0, 32'd8);
        @(posedge clk); #1;

        // Reset in the middle of a shift: result must vanish for good.
        drive(3'd6, 32'd1, 32'd20, acc);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_zero", {31'd0, Zero}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        run_op("post_rst_add", 3'd0, 32'd1, 32'd1, 32'd2, 1);

        // Randomized traffic with a randomly stalling consumer.
        rand_or = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if (op >= 3'd6 && $urandom_range(0, 1) == 0) b = b & 32'hFFFF_FFE7;
            drive(op, a, b, acc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_or  = 1'b0;
        or_fixed = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("drained", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
